debug_dump_tx: RTL

- Transmit side of the debug UART link. Answers the receive path, which loads program instructions and commands.
- On a start request it walks a window of 32-bit debug words: pipeline latches, register file, data memory or PC.
- For each word it drives a word index to the latch/register mux, captures the returned word, and serialises it as 4 UART bytes, LSB byte first.
- Sits beside the debug unit and drives the board TX pin.

---
 rtl/debug_dump_tx.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/debug_dump_tx.sv
// debug_dump_tx
// Transmit side of the debug UART link. On a start request it walks
// num_words 32-bit debug words. For each word it drives word_sel to the
// latch/register mux, captures word_data one cycle later, and sends the word
// as four 8N1 UART bytes, least significant byte first.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      single-cycle dump request (ignored unless idle)
//   num_words  number of words to dump, sampled with start
//   word_sel   index of the word currently requested from the mux
//   word_data  mux output, valid one cycle after word_sel changes
//   tx         UART serial output, idle high
//   busy       dump in progress
//   done       single-cycle pulse when the dump completes
//
// Optional build macro: DEBUG_DUMP_FRAMING_EN
//   When defined, each dump is wrapped as: 0xA5, num_words[7:0], data bytes,
//   then the XOR of all data bytes.
module debug_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SEL_W        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W:0]   num_words,
  output logic [SEL_W-1:0] word_sel,
  input  logic [31:0]      word_data,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W  = SEL_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CAPTURE, S_SEND, S_WAIT, S_FINISH
  } state_t;

  state_t r_state, w_state_next;

  logic [CNT_W-1:0] r_count;
  logic [SEL_W-1:0] r_word_sel;
  logic [31:0]      r_shift;
  logic [1:0]       r_byte_cnt;

  logic              r_ser_active;
  logic [3:0]        r_bit_idx;
  logic [BAUD_W-1:0] r_baud;
  logic [7:0]        r_ser_data;
  logic              r_tx;

  logic             w_ser_start;
  logic             w_byte_done;
  logic [CNT_W-1:0] w_sel_inc;
  logic             w_last_word;

`ifdef DEBUG_DUMP_FRAMING_EN
  localparam logic [1:0] PH_HDR  = 2'd0;
  localparam logic [1:0] PH_DATA = 2'd1;
  localparam logic [1:0] PH_TRL  = 2'd2;
  logic [1:0] r_phase;
  logic [7:0] r_xor;
  logic [7:0] w_len_byte;
  assign w_len_byte = 8'(num_words);
`endif

  assign word_sel    = r_word_sel;
  assign tx          = r_tx;
  // Terminal compare is done at SEL_W+1 bits so a full 2^SEL_W dump works.
  assign w_sel_inc   = {1'b0, r_word_sel} + CNT_W'(1);
  assign w_last_word = (w_sel_inc == r_count);
  // Last cycle of the stop bit.
  assign w_byte_done = r_ser_active && (r_bit_idx == 4'd9) && (r_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ser_start  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DEBUG_DUMP_FRAMING_EN
          w_state_next = S_SEND;
`else
          w_state_next = (num_words == '0) ? S_FINISH : S_SELECT;
`endif
        end
      end
      S_SELECT: begin
        busy         = 1'b1;
        w_state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy         = 1'b1;
        w_state_next = S_SEND;
      end
      S_SEND: begin
        busy         = 1'b1;
        w_ser_start  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (w_byte_done) begin
          if (r_byte_cnt != 2'd3) begin
            w_state_next = S_SEND;
          end else begin
`ifdef DEBUG_DUMP_FRAMING_EN
            case (r_phase)
              PH_TRL:  w_state_next = S_FINISH;
              PH_HDR:  w_state_next = (r_count == '0) ? S_SEND : S_SELECT;
              default: w_state_next = w_last_word ? S_SEND : S_SELECT;
            endcase
`else
            w_state_next = w_last_word ? S_FINISH : S_SELECT;
`endif
          end
        end
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Word datapath: count, word index, byte shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_word_sel <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
`ifdef DEBUG_DUMP_FRAMING_EN
      r_phase    <= PH_HDR;
      r_xor      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count    <= num_words;
            r_word_sel <= '0;
`ifdef DEBUG_DUMP_FRAMING_EN
            // Header and length share the shift register; starting the byte
            // counter at 2 makes them a two-byte "word".
            r_shift    <= {16'h0000, w_len_byte, 8'hA5};
            r_byte_cnt <= 2'd2;
            r_phase    <= PH_HDR;
            r_xor      <= '0;
`endif
          end
        end
        S_CAPTURE: begin
          r_shift    <= word_data;
          r_byte_cnt <= 2'd0;
`ifdef DEBUG_DUMP_FRAMING_EN
          r_phase    <= PH_DATA;
          r_xor      <= r_xor ^ word_data[7:0] ^ word_data[15:8]
                              ^ word_data[23:16] ^ word_data[31:24];
`endif
        end
        S_WAIT: begin
          if (w_byte_done) begin
            r_shift    <= r_shift >> 8;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
`ifdef DEBUG_DUMP_FRAMING_EN
              // The trailer is a one-byte "word": counter preset to 3.
              if ((r_phase == PH_HDR && r_count == '0) ||
                  (r_phase == PH_DATA && w_last_word)) begin
                r_shift    <= {24'h000000, r_xor};
                r_byte_cnt <= 2'd3;
                r_phase    <= PH_TRL;
                r_word_sel <= '0;
              end else if (r_phase == PH_DATA) begin
                r_word_sel <= r_word_sel + SEL_W'(1);
              end
`else
              // Never wrap past the last index; park at 0 instead.
              if (w_last_word) r_word_sel <= '0;
              else             r_word_sel <= r_word_sel + SEL_W'(1);
`endif
            end
          end
        end
        S_FINISH: r_word_sel <= '0;
        default: ;
      endcase
    end
  end

  // Bit serialiser: start bit, 8 data bits LSB first, stop bit.
  // Ones are shifted in behind the data so the stop bit falls out naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ser_active <= 1'b0;
      r_bit_idx    <= '0;
      r_baud       <= '0;
      r_ser_data   <= '0;
      r_tx         <= 1'b1;
    end else if (w_ser_start) begin
      r_ser_active <= 1'b1;
      r_bit_idx    <= '0;
      r_baud       <= '0;
      r_ser_data   <= r_shift[7:0];
      r_tx         <= 1'b0;
    end else if (r_ser_active) begin
      if (r_baud == BAUD_LAST) begin
        r_baud <= '0;
        if (r_bit_idx == 4'd9) begin
          r_ser_active <= 1'b0;
          r_tx         <= 1'b1;
        end else begin
          r_bit_idx  <= r_bit_idx + 4'd1;
          r_tx       <= r_ser_data[0];
          r_ser_data <= {1'b1, r_ser_data[7:1]};
        end
      end else begin
        r_baud <= r_baud + BAUD_W'(1);
      end
    end
  end

endmodule
